// File: rtl/rubik_status_pkg.sv
// Shared event codes, source ordering and TX FSM encoding for the host status link.
package rubik_status_pkg;

  localparam logic [7:0] EVT_DIR_BASE  = 8'hD0;
  localparam logic [7:0] EVT_GRIP_BASE = 8'hD8;
  localparam logic [7:0] EVT_SCAN_DONE = 8'h5C;

  // Source index 0..3 = dir1..dir4, 4..7 = grip1..grip4, 8 = scanner (also the priority order)
  localparam int unsigned NUM_SRC = 9;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_e;

  typedef struct packed {
    logic [3:0] grip;
    logic [3:0] dir;
  } servo_done_t;

  function automatic logic [3:0] first_set(input logic [NUM_SRC-1:0] v);
    logic [3:0] idx;
    idx = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (v[i]) idx = 4'(i);
    end
    return idx;
  endfunction

  function automatic logic [7:0] evt_code(input logic [3:0] idx);
    logic [7:0] code;
    if (idx < 4'd4)      code = EVT_DIR_BASE  | {6'd0, idx[1:0]};
    else if (idx < 4'd8) code = EVT_GRIP_BASE | {6'd0, idx[1:0]};
    else                 code = EVT_SCAN_DONE;
    return code;
  endfunction

endpackage

// File: rtl/uart_status_tx_if.sv
// Host-facing signal bundle of uart_status_tx: done taps and enable in, UART line and status out.
interface uart_status_tx_if #(
  parameter int unsigned FIFO_DEPTH = 8
);
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic             I_enable;
  logic [3:0]       I_direction_done;
  logic [3:0]       I_gripping_done;
  logic             I_scanner_done;
  logic             o_tx_serial;
  logic             o_tx_busy;
  logic [CNT_W-1:0] o_fifo_count;
  logic             o_overflow;

  modport master (
    output I_enable, I_direction_done, I_gripping_done, I_scanner_done,
    input  o_tx_serial, o_tx_busy, o_fifo_count, o_overflow
  );

  modport slave (
    input  I_enable, I_direction_done, I_gripping_done, I_scanner_done,
    output o_tx_serial, o_tx_busy, o_fifo_count, o_overflow
  );
endinterface

// File: rtl/uart_tx_serializer.sv
// UART 8N1 serializer: takes one byte per frame on a valid/ready handshake, sends LSB first.
module uart_tx_serializer
  import rubik_status_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 868
) (
  input  logic       I_sys_clk,
  input  logic       I_rst_n,
  input  logic [7:0] I_data,
  input  logic       I_valid,
  output logic       o_ready,
  output logic       o_tx_serial,
  output logic       o_tx_busy
);

  localparam int unsigned BAUD_W = $clog2(CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

  tx_state_e         state_q;
  logic [BAUD_W-1:0] baud_q;
  logic [2:0]        bit_q;
  logic [7:0]        shift_q;
  logic              tx_q;
  logic              busy_q;
  logic              ready_q;
  logic              baud_end;

  assign baud_end = (baud_q == BAUD_LAST);

  // Line, busy and ready are updated together with the state so all outputs are flops
  always_ff @(posedge I_sys_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      state_q <= TX_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      baud_q <= (state_q == TX_IDLE || baud_end) ? '0 : baud_q + BAUD_W'(1);
      case (state_q)
        TX_IDLE: begin
          if (I_valid) begin
            shift_q <= I_data;
            state_q <= TX_START;
            tx_q    <= 1'b0;
            busy_q  <= 1'b1;
            ready_q <= 1'b0;
          end
        end
        TX_START: begin
          if (baud_end) begin
            state_q <= TX_DATA;
            bit_q   <= '0;
            tx_q    <= shift_q[0];
          end
        end
        TX_DATA: begin
          if (baud_end) begin
            shift_q <= {1'b0, shift_q[7:1]};
            if (bit_q == 3'd7) begin
              state_q <= TX_STOP;
              tx_q    <= 1'b1;
            end else begin
              bit_q <= bit_q + 3'd1;
              tx_q  <= shift_q[1];
            end
          end
        end
        TX_STOP: begin
          if (baud_end) begin
            state_q <= TX_IDLE;
            busy_q  <= 1'b0;
            ready_q <= 1'b1;
          end
        end
        default: state_q <= TX_IDLE;
      endcase
    end
  end

  assign o_ready     = ready_q;
  assign o_tx_serial = tx_q;
  assign o_tx_busy   = busy_q;

endmodule

// File: rtl/uart_status_tx.sv
// Status event reporter: syncs the done taps, queues one-byte event codes and sends them to the host.
module uart_status_tx
  import rubik_status_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned FIFO_DEPTH   = 8
) (
  input  logic               I_sys_clk,
  input  logic               I_rst_n,
  uart_status_tx_if.slave    bus
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  servo_done_t        sync1_q;
  servo_done_t        sync2_q;
  logic               scan_q;
  logic [NUM_SRC-1:0] prev_q;
  logic [NUM_SRC-1:0] pend_q;
  logic [NUM_SRC-1:0] pend_d;
  logic               ovf_q;

  logic [7:0]         mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q;
  logic [PTR_W-1:0]   rd_ptr_q;
  logic [CNT_W-1:0]   count_q;

  logic [NUM_SRC-1:0] lvl;
  logic [NUM_SRC-1:0] evt;
  logic [NUM_SRC-1:0] grant;
  logic [3:0]         grant_idx;
  logic               fifo_empty;
  logic               fifo_full;
  logic               fifo_wr;
  logic               fifo_rd;
  logic               ser_ready;

  assign lvl        = {scan_q, sync2_q};
  assign evt        = (lvl & ~prev_q) & {NUM_SRC{bus.I_enable}};
  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == CNT_W'(FIFO_DEPTH));
  assign fifo_rd    = ser_ready & ~fifo_empty;
  // A full FIFO still accepts a write when the serializer pops in the same cycle
  assign fifo_wr    = (|pend_q) & (~fifo_full | fifo_rd);
  assign grant_idx  = first_set(pend_q);
  assign grant      = fifo_wr ? (NUM_SRC'(1) << grant_idx) : '0;
  // A repeat event on a still-pending source is dropped; the pending bit is kept
  assign pend_d     = (pend_q & ~grant) | (evt & ~pend_q);

  always_ff @(posedge I_sys_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      scan_q   <= 1'b0;
      prev_q   <= '0;
      pend_q   <= '0;
      ovf_q    <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      sync1_q <= '{grip: bus.I_gripping_done, dir: bus.I_direction_done};
      sync2_q <= sync1_q;
      scan_q  <= bus.I_scanner_done;
      prev_q  <= lvl;
      pend_q  <= pend_d;
      if (|(evt & pend_q)) ovf_q <= 1'b1;
      if (fifo_wr) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (fifo_rd) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_q + CNT_W'(fifo_wr) - CNT_W'(fifo_rd);
    end
  end

  // Event storage needs no reset: entries are only read once written
  always_ff @(posedge I_sys_clk) begin
    if (fifo_wr) mem_q[wr_ptr_q] <= evt_code(grant_idx);
  end

  uart_tx_serializer #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_ser (
    .I_sys_clk   (I_sys_clk),
    .I_rst_n     (I_rst_n),
    .I_data      (mem_q[rd_ptr_q]),
    .I_valid     (~fifo_empty),
    .o_ready     (ser_ready),
    .o_tx_serial (bus.o_tx_serial),
    .o_tx_busy   (bus.o_tx_busy)
  );

  assign bus.o_fifo_count = count_q;
  assign bus.o_overflow   = ovf_q;

endmodule
